// File: rtl/alu_op_encoder.sv
// alu_op_encoder
// ID/EX-stage ALU control encoder and pipeline register.
// Decodes a MIPS32 instruction word into the 4-bit ALU operation code plus
// operand-select, trap, write-back and validity controls, registered with
// stall/flush handling and a saturating counter of unsupported instructions.
//
// Optional feature: define ALU_VARSHIFT_EN to accept the variable shifts
// sllv (fn 0x04) and srlv (fn 0x06); without it those encodings are illegal.

module alu_op_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [3:0]  alu_con,
    output logic        alu_src_imm,
    output logic        shamt_sel,
    output logic [31:0] imm_ext,
    output logic        ov_trap_en,
    output logic [4:0]  reg_dst,
    output logic        reg_write,
    output logic        out_valid,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);

    // ALU operation codes seen by the execute stage
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLL  = 4'h6;
    localparam logic [3:0] ALU_SRL  = 4'h7;
    localparam logic [3:0] ALU_ADDU = 4'hE;
    localparam logic [3:0] ALU_SUBU = 4'hF;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
`ifdef ALU_VARSHIFT_EN
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
`endif
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;

    // Instruction fields
    logic [5:0]  w_op;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_sh;
    logic [5:0]  w_fn;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic        w_unused_rs;

    assign w_op   = instr[31:26];
    assign w_rt   = instr[20:16];
    assign w_rd   = instr[15:11];
    assign w_sh   = instr[10:6];
    assign w_fn   = instr[5:0];
    assign w_sext = {{16{instr[15]}}, instr[15:0]};
    assign w_zext = {16'h0000, instr[15:0]};
    // rs selects a register-file read port upstream; it does not steer any control here
    assign w_unused_rs = ^instr[25:21];

    // Decoded (unregistered) controls
    logic        w_legal;
    logic [3:0]  w_con;
    logic        w_src_imm;
    logic        w_shamt_sel;
    logic [31:0] w_imm;
    logic        w_trap;
    logic [4:0]  w_dst;
    logic        w_writes;
    logic        w_reg_write;

    // Combinational decode of the incoming instruction word
    always_comb begin
        w_legal     = 1'b0;
        w_con       = 4'h0;
        w_src_imm   = 1'b0;
        w_shamt_sel = 1'b0;
        w_imm       = 32'h0;
        w_trap      = 1'b0;
        w_dst       = 5'd0;
        w_writes    = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_fn)
                    FN_ADD:  begin w_legal = 1'b1; w_con = ALU_ADD;  w_trap = 1'b1; end
                    FN_ADDU: begin w_legal = 1'b1; w_con = ALU_ADDU; end
                    FN_SUB:  begin w_legal = 1'b1; w_con = ALU_SUB;  w_trap = 1'b1; end
                    FN_SUBU: begin w_legal = 1'b1; w_con = ALU_SUBU; end
                    FN_AND:  begin w_legal = 1'b1; w_con = ALU_AND;  end
                    FN_OR:   begin w_legal = 1'b1; w_con = ALU_OR;   end
                    FN_XOR:  begin w_legal = 1'b1; w_con = ALU_XOR;  end
                    FN_NOR:  begin w_legal = 1'b1; w_con = ALU_NOR;  end
                    FN_SLL: begin
                        w_legal     = 1'b1;
                        w_con       = ALU_SLL;
                        w_shamt_sel = 1'b1;
                        w_imm       = {27'h0, w_sh};
                    end
                    FN_SRL: begin
                        w_legal     = 1'b1;
                        w_con       = ALU_SRL;
                        w_shamt_sel = 1'b1;
                        w_imm       = {27'h0, w_sh};
                    end
`ifdef ALU_VARSHIFT_EN
                    // Variable shifts take the amount from rs, so no immediate
                    FN_SLLV: begin w_legal = 1'b1; w_con = ALU_SLL; end
                    FN_SRLV: begin w_legal = 1'b1; w_con = ALU_SRL; end
`endif
                    default: begin end
                endcase
                if (w_legal) begin
                    w_dst    = w_rd;
                    w_writes = 1'b1;
                end
            end
            OP_ADDI: begin
                w_legal = 1'b1; w_con = ALU_ADD; w_src_imm = 1'b1;
                w_imm = w_sext; w_trap = 1'b1; w_dst = w_rt; w_writes = 1'b1;
            end
            OP_ADDIU: begin
                w_legal = 1'b1; w_con = ALU_ADDU; w_src_imm = 1'b1;
                w_imm = w_sext; w_dst = w_rt; w_writes = 1'b1;
            end
            OP_ANDI: begin
                w_legal = 1'b1; w_con = ALU_AND; w_src_imm = 1'b1;
                w_imm = w_zext; w_dst = w_rt; w_writes = 1'b1;
            end
            OP_ORI: begin
                w_legal = 1'b1; w_con = ALU_OR; w_src_imm = 1'b1;
                w_imm = w_zext; w_dst = w_rt; w_writes = 1'b1;
            end
            OP_XORI: begin
                w_legal = 1'b1; w_con = ALU_XOR; w_src_imm = 1'b1;
                w_imm = w_zext; w_dst = w_rt; w_writes = 1'b1;
            end
            OP_LW: begin
                w_legal = 1'b1; w_con = ALU_ADDU; w_src_imm = 1'b1;
                w_imm = w_sext; w_dst = w_rt; w_writes = 1'b1;
            end
            OP_SW: begin
                // Address add only; the store never writes the register file
                w_legal = 1'b1; w_con = ALU_ADDU; w_src_imm = 1'b1;
                w_imm = w_sext; w_dst = w_rt;
            end
            OP_BEQ, OP_BNE: begin
                // Comparison by subtraction of rs and rt; the offset is passed
                // along sign-extended for the branch-target adder
                w_legal = 1'b1; w_con = ALU_SUBU; w_imm = w_sext;
            end
            default: begin end
        endcase
    end

    // Writing $0 is architecturally a no-op, so suppress the write-back
    assign w_reg_write = w_writes & (w_dst != 5'd0);

    // Registered slot
    logic [3:0]  r_con;
    logic        r_src_imm;
    logic        r_shamt_sel;
    logic [31:0] r_imm;
    logic        r_trap;
    logic [4:0]  r_dst;
    logic        r_reg_write;
    logic        r_valid;
    logic        r_illegal;
    logic [7:0]  r_illegal_cnt;

    // Next slot contents
    logic [3:0]  w_nxt_con;
    logic        w_nxt_src_imm;
    logic        w_nxt_shamt_sel;
    logic [31:0] w_nxt_imm;
    logic        w_nxt_trap;
    logic [4:0]  w_nxt_dst;
    logic        w_nxt_reg_write;
    logic        w_nxt_valid;
    logic        w_nxt_illegal;
    logic        w_cnt_inc;

    // Slot update priority: flush squashes, stall holds, otherwise load decode or bubble
    always_comb begin
        w_nxt_con       = 4'h0;
        w_nxt_src_imm   = 1'b0;
        w_nxt_shamt_sel = 1'b0;
        w_nxt_imm       = 32'h0;
        w_nxt_trap      = 1'b0;
        w_nxt_dst       = 5'd0;
        w_nxt_reg_write = 1'b0;
        w_nxt_valid     = 1'b0;
        w_nxt_illegal   = 1'b0;
        if (flush) begin
            // all-zero slot
        end else if (stall) begin
            w_nxt_con       = r_con;
            w_nxt_src_imm   = r_src_imm;
            w_nxt_shamt_sel = r_shamt_sel;
            w_nxt_imm       = r_imm;
            w_nxt_trap      = r_trap;
            w_nxt_dst       = r_dst;
            w_nxt_reg_write = r_reg_write;
            w_nxt_valid     = r_valid;
            w_nxt_illegal   = r_illegal;
        end else if (in_valid) begin
            if (w_legal) begin
                w_nxt_con       = w_con;
                w_nxt_src_imm   = w_src_imm;
                w_nxt_shamt_sel = w_shamt_sel;
                w_nxt_imm       = w_imm;
                w_nxt_trap      = w_trap;
                w_nxt_dst       = w_dst;
                w_nxt_reg_write = w_reg_write;
                w_nxt_valid     = 1'b1;
            end else begin
                w_nxt_illegal   = 1'b1;
            end
        end
    end

    // Only a genuine load of an unsupported instruction is counted
    assign w_cnt_inc = in_valid & ~w_legal & ~stall & ~flush;

    // ID/EX control register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_con       <= 4'h0;
            r_src_imm   <= 1'b0;
            r_shamt_sel <= 1'b0;
            r_imm       <= 32'h0;
            r_trap      <= 1'b0;
            r_dst       <= 5'd0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_con       <= w_nxt_con;
            r_src_imm   <= w_nxt_src_imm;
            r_shamt_sel <= w_nxt_shamt_sel;
            r_imm       <= w_nxt_imm;
            r_trap      <= w_nxt_trap;
            r_dst       <= w_nxt_dst;
            r_reg_write <= w_nxt_reg_write;
            r_valid     <= w_nxt_valid;
            r_illegal   <= w_nxt_illegal;
        end
    end

    // Saturating count of illegal-instruction loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_cnt <= 8'h00;
        end else if (w_cnt_inc && (r_illegal_cnt != 8'hFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 8'h01;
        end
    end

    assign alu_con     = r_con;
    assign alu_src_imm = r_src_imm;
    assign shamt_sel   = r_shamt_sel;
    assign imm_ext     = r_imm;
    assign ov_trap_en  = r_trap;
    assign reg_dst     = r_dst;
    assign reg_write   = r_reg_write;
    assign out_valid   = r_valid;
    assign illegal     = r_illegal;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Testbench for alu_op_encoder: directed steps followed by randomized traffic,
// all compared against a table-driven reference model of the decode rules.
// Honors ALU_VARSHIFT_EN the same way as the design.

module tb_alu_op_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [3:0]  alu_con;
    logic        alu_src_imm;
    logic        shamt_sel;
    logic [31:0] imm_ext;
    logic        ov_trap_en;
    logic [4:0]  reg_dst;
    logic        reg_write;
    logic        out_valid;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    alu_op_encoder dut (
        .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid),
        .stall(stall), .flush(flush), .alu_con(alu_con),
        .alu_src_imm(alu_src_imm), .shamt_sel(shamt_sel), .imm_ext(imm_ext),
        .ov_trap_en(ov_trap_en), .reg_dst(reg_dst), .reg_write(reg_write),
        .out_valid(out_valid), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  con;
        logic        src_imm;
        logic        shamt_sel;
        logic [31:0] imm;
        logic        trap;
        logic [4:0]  dst;
        logic        wr;
        logic        vld;
        logic        ill;
        logic        dc;      // reg_dst / imm_ext not defined for this slot
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q;
    int   cnt_q;

    // R-type table: fn -> {trap, shamt-from-instr, con}
    logic [7:0] rtab [int];
    // I-type table: op -> {writes, sign-extend, trap, con}
    logic [7:0] itab [int];

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t       e;
        logic [7:0] ent;
        int         op;
        int         fn;
        e  = '0;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        if (op == 0 && rtab.exists(fn)) begin
            ent         = rtab[fn];
            e.con       = ent[3:0];
            e.shamt_sel = ent[4];
            e.trap      = ent[5];
            e.imm       = ent[4] ? {27'h0, w[10:6]} : 32'h0;
            e.dst       = w[15:11];
            e.wr        = (w[15:11] != 5'd0);
            e.vld       = 1'b1;
        end else if (itab.exists(op)) begin
            ent       = itab[op];
            e.con     = ent[3:0];
            e.trap    = ent[4];
            e.imm     = ent[5] ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
            e.src_imm = 1'b1;
            e.dst     = w[20:16];
            e.wr      = ent[6] && (w[20:16] != 5'd0);
            e.vld     = 1'b1;
        end else if (op == 4 || op == 5) begin
            e.con = 4'hF;
            e.vld = 1'b1;
            e.dc  = 1'b1;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  rfn [0:11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                    6'h26, 6'h27, 6'h00, 6'h02, 6'h04, 6'h06};
        logic [5:0]  iop [0:8]  = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E,
                                    6'h23, 6'h2B, 6'h04, 6'h05};
        w = $urandom;
        case ($urandom_range(0, 3))
            0: begin w[31:26] = 6'h00; w[5:0] = rfn[$urandom_range(0, 11)]; end
            1: begin w[31:26] = iop[$urandom_range(0, 8)]; end
            2: begin end
            default: begin
                w[31:26] = 6'h00; w[5:0] = rfn[$urandom_range(0, 11)];
                w[15:11] = 5'd0; w[20:16] = 5'd0;
            end
        endcase
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_slot(input string tag);
        chk({tag, " out_valid"},   32'(out_valid),   32'(exp_q.vld));
        chk({tag, " illegal"},     32'(illegal),     32'(exp_q.ill));
        chk({tag, " alu_con"},     32'(alu_con),     32'(exp_q.con));
        chk({tag, " alu_src_imm"}, 32'(alu_src_imm), 32'(exp_q.src_imm));
        chk({tag, " shamt_sel"},   32'(shamt_sel),   32'(exp_q.shamt_sel));
        chk({tag, " ov_trap_en"},  32'(ov_trap_en),  32'(exp_q.trap));
        chk({tag, " reg_write"},   32'(reg_write),   32'(exp_q.wr));
        if (!exp_q.dc) begin
            chk({tag, " reg_dst"}, 32'(reg_dst), 32'(exp_q.dst));
            chk({tag, " imm_ext"}, imm_ext,      exp_q.imm);
        end
        chk({tag, " illegal_cnt"}, 32'(illegal_cnt), 32'(cnt_q));
    endtask

    task automatic step(input logic [31:0] ins, input logic v, input logic st,
                        input logic fl, input string tag);
        instr    = ins;
        in_valid = v;
        stall    = st;
        flush    = fl;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q = '0;
        end else if (!st) begin
            if (v) begin
                exp_q = ref_decode(ins);
                if (exp_q.ill && cnt_q < 255) cnt_q++;
            end else begin
                exp_q = '0;
            end
        end
        check_slot(tag);
    endtask

    initial begin
        int prev_cnt;
        rtab[32'h20] = 8'h20; rtab[32'h21] = 8'h0E; rtab[32'h22] = 8'h21;
        rtab[32'h23] = 8'h0F; rtab[32'h24] = 8'h02; rtab[32'h25] = 8'h03;
        rtab[32'h26] = 8'h04; rtab[32'h27] = 8'h05; rtab[32'h00] = 8'h16;
        rtab[32'h02] = 8'h17;
`ifdef ALU_VARSHIFT_EN
        rtab[32'h04] = 8'h06; rtab[32'h06] = 8'h07;
`endif
        itab[32'h08] = 8'h70; itab[32'h09] = 8'h6E; itab[32'h0C] = 8'h42;
        itab[32'h0D] = 8'h43; itab[32'h0E] = 8'h44; itab[32'h23] = 8'h6E;
        itab[32'h2B] = 8'h2E;

        // Reset with a live instruction presented
        rst = 1'b1; instr = 32'h01095020; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        exp_q = '0; cnt_q = 0;
        #1;
        check_slot("reset_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_slot("reset_hold");
        end
        rst = 1'b0;

        step(32'h01095020, 1'b1, 1'b0, 1'b0, "add");
        chk("add lit con", 32'(alu_con), 32'h0);
        chk("add lit dst", 32'(reg_dst), 32'd10);
        chk("add lit trap", 32'(ov_trap_en), 32'h1);

        step(32'h2128FFFF, 1'b1, 1'b0, 1'b0, "addi");
        chk("addi lit imm", imm_ext, 32'hFFFFFFFF);
        step(32'h3128FFFF, 1'b1, 1'b0, 1'b0, "andi");
        chk("andi lit imm", imm_ext, 32'h0000FFFF);
        chk("andi lit trap", 32'(ov_trap_en), 32'h0);

        step(32'h00094080, 1'b1, 1'b0, 1'b0, "sll");
        chk("sll lit con", 32'(alu_con), 32'h6);
        chk("sll lit imm", imm_ext, 32'h2);
        step(32'h00000000, 1'b1, 1'b0, 1'b0, "nop");
        chk("nop lit wr", 32'(reg_write), 32'h0);
        chk("nop lit vld", 32'(out_valid), 32'h1);

        step(32'h01095022, 1'b1, 1'b0, 1'b0, "sub");
        for (int i = 0; i < 3; i++) begin
            step(rand_instr(), 1'b1, 1'b1, 1'b0, "stall");
            chk("stall lit con", 32'(alu_con), 32'h1);
        end
        step(32'h01095020, 1'b1, 1'b1, 1'b1, "stall_flush");
        chk("stall_flush lit vld", 32'(out_valid), 32'h0);

        step(32'h01095020, 1'b0, 1'b0, 1'b0, "bubble");

        prev_cnt = cnt_q;
        step(32'h01094004, 1'b1, 1'b0, 1'b0, "sllv");
`ifdef ALU_VARSHIFT_EN
        chk("sllv lit con", 32'(alu_con), 32'h6);
        chk("sllv lit shamt_sel", 32'(shamt_sel), 32'h0);
`else
        chk("sllv lit illegal", 32'(illegal), 32'h1);
        chk("sllv lit cnt", 32'(illegal_cnt), 32'(prev_cnt + 1));
`endif

        // Randomized traffic with occasional bubbles, stalls and flushes
        repeat (400) begin
            step(rand_instr(), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0), "rand");
        end

        repeat (300) step(32'hFC000000, 1'b1, 1'b0, 1'b0, "illegal_run");
        chk("illegal_run lit cnt", 32'(illegal_cnt), 32'hFF);
        chk("illegal_run lit ill", 32'(illegal), 32'h1);

        // Asynchronous reset in the middle of traffic
        step(32'h01095020, 1'b1, 1'b0, 1'b0, "pre_reset");
        #2;
        rst = 1'b1;
        #1;
        exp_q = '0;
        cnt_q = 0;
        check_slot("mid_reset");
        @(posedge clk);
        #1;
        check_slot("mid_reset_hold");
        @(negedge clk);
        rst = 1'b0;
        step(32'h01095020, 1'b1, 1'b0, 1'b0, "post_reset");
        chk("post_reset lit vld", 32'(out_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_encoder.md
# alu_op_encoder

ID/EX-stage encoder that turns a fetched MIPS32 instruction word into the 4-bit ALU operation code and operand-select controls consumed by the execute-stage ALU. It is the producing end of the ALU control interface, and it also acts as the ID/EX pipeline register for those controls. It supports stall and flush, flags unsupported instructions, and counts them in a saturating counter.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr  in  32  instruction word from IF/ID
- in_valid  in  1  instr is a real instruction (0 = bubble)
- stall  in  1  hold all registered outputs
- flush  in  1  squash the slot being loaded
- alu_con  out  4  ALU op: add 0, sub 1, and 2, or 3, xor 4, nor 5, sll 6, srl 7, addu E, subu F
- alu_src_imm  out  1  ALU In2 = imm_ext (else rt value)
- shamt_sel  out  1  shift by imm_ext[4:0] (instr[10:6]) instead of rs
- imm_ext  out  32  extended immediate or shamt
- ov_trap_en  out  1  execute stage traps when the ALU reports overflow
- reg_dst  out  5  destination register number
- reg_write  out  1  write-back enabled
- out_valid  out  1  registered slot holds a valid instruction
- illegal  out  1  registered slot was unsupported (out_valid = 0)
- illegal_cnt  out  8  saturating count of illegal instructions

## Operation
- Field split: op = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], sh = [10:6], fn = [5:0].
- R-type (op 0), reg_dst = rd, alu_src_imm = 0:
  - fn 20 add: con 0, trap 1
  - fn 21 addu: con E
  - fn 22 sub: con 1, trap 1
  - fn 23 subu: con F
  - fn 24 and: con 2
  - fn 25 or: con 3
  - fn 26 xor: con 4
  - fn 27 nor: con 5
  - fn 00 sll: con 6, shamt_sel 1, imm_ext = {27'b0, sh}
  - fn 02 srl: con 7, shamt_sel 1, imm_ext = {27'b0, sh}
- I-type, reg_dst = rt, alu_src_imm = 1:
  - op 08 addi: con 0, sign-extend, trap 1
  - op 09 addiu: con E, sign-extend
  - op 0C andi: con 2, zero-extend
  - op 0D ori: con 3, zero-extend
  - op 0E xori: con 4, zero-extend
  - op 23 lw: con E, sign-extend, reg_write 1
  - op 2B sw: con E, sign-extend, reg_write 0
- Branches op 04/05 (beq/bne): con F, alu_src_imm 0, reg_write 0.
- reg_write = 1 for all ALU-writing instructions whose reg_dst ≠ 0. Instruction 0x00000000 is therefore a harmless nop: out_valid 1, reg_write 0.
- Any other op/fn is illegal. Its slot loads out_valid 0, illegal 1, and all other controls 0.
- ov_trap_en is 0 whenever the trap column above does not list it.
- Control-register update, priority flush > stall > load:
  - flush: out_valid, illegal, reg_write, ov_trap_en ← 0; remaining outputs don't-care, driven 0.
  - stall (no flush): all outputs hold.
  - load: decode instr when in_valid = 1; in_valid = 0 loads a bubble (all 0).
- illegal_cnt increments by 1 on each load of an illegal slot and saturates at 0xFF. Flush and stall do not count.

## Timing
- Reset is asynchronous. While rst = 1, every output including illegal_cnt is 0.
- Latency is one cycle: instr sampled at edge N appears on the outputs after edge N. Throughput is 1 instruction/clk.
- A flush coincident with stall still squashes the slot.
- A stall held for k cycles holds the outputs unchanged for k cycles.
- Reset asserted mid-stream clears the slot and the counter immediately, without waiting for a clock edge. The first load after release is the first valid slot.

## Configuration
- ALU_VARSHIFT_EN defined: R-type fn 04 sllv → con 6 and fn 06 srlv → con 7, each with shamt_sel 0 (shift amount from rs) and imm_ext 0.
- ALU_VARSHIFT_EN undefined: fn 04 and fn 06 are illegal.

## Test plan
- Reset: rst = 1 for 2 cycles with in_valid = 1, instr = 0x01095020 (add $10,$8,$9) -> all outputs 0. After release and one clk -> alu_con 0, reg_dst 10, reg_write 1, ov_trap_en 1, out_valid 1.
- Immediates: addi 0x2128FFFF -> con 0, imm_ext 0xFFFFFFFF, trap 1. andi 0x3128FFFF -> con 2, imm_ext 0x0000FFFF, trap 0.
- Shift: sll 0x00094080 (sll $8,$9,2) -> con 6, shamt_sel 1, imm_ext 2. Instruction 0x00000000 -> out_valid 1, reg_write 0.
- Stall/flush: load sub, then stall = 1 for 3 cycles while instr changes -> con stays 1. Assert stall = 1 and flush = 1 together -> out_valid 0.
- Illegal: 300 consecutive loads of 0xFC000000 -> illegal 1, out_valid 0, illegal_cnt ends at 0xFF.
- Macro: sllv 0x01094004 -> with ALU_VARSHIFT_EN, con 6 and shamt_sel 0; without it, illegal 1 and illegal_cnt +1.
